// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - two-stage RV32I issue front-end for a combinational 32-bit ALU
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            upstream handshake for decoded op + operands
//   in_opcode/funct3/funct7      instruction fields used for decode
//   in_rs1/in_rs2/in_imm/in_rd   operand values, sign-extended I-immediate, destination
//   alu_a/alu_b/alu_sel          registered drive into the external ALU
//   alu_result/alu_zero          combinational ALU outputs, captured into the output stage
//   out_valid/out_ready          downstream handshake for the result register
//   out_result/out_rd/out_wb_en  writeback payload
//   out_branch/out_taken         BEQ/BNE resolution
//   out_illegal                  op was not recognised
module alu_issue_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RD_W-1:0] in_rd,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_sel,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wb_en,
  output logic            out_branch,
  output logic            out_taken,
  output logic            out_illegal
);

  typedef enum logic [1:0] {K_ALU = 2'd0, K_BEQ = 2'd1, K_BNE = 2'd2} kind_t;

  localparam logic [2:0] SEL_ADD = 3'd0, SEL_SUB = 3'd1, SEL_AND = 3'd2, SEL_OR = 3'd3,
                         SEL_XOR = 3'd4, SEL_SLT = 3'd5, SEL_SLL = 3'd6, SEL_SRL = 3'd7;

  logic [XLEN-1:0] d_a, d_b;
  logic [2:0]      d_sel;
  kind_t           d_kind;
  logic            d_illegal;
  logic            f7_zero, shamt_ok;

  assign f7_zero  = (in_funct7 == 7'b0000000);
  assign shamt_ok = (in_imm[11:5] == 7'b0000000);

  always_comb begin
    d_a       = '0;
    d_b       = '0;
    d_sel     = SEL_ADD;
    d_kind    = K_ALU;
    d_illegal = 1'b1;
    case (in_opcode)
      7'b0110011: begin
        d_a = in_rs1;
        d_b = in_rs2;
        case (in_funct3)
          3'b000: begin
            if (f7_zero) begin
              d_sel = SEL_ADD; d_illegal = 1'b0;
            end else if (in_funct7 == 7'b0100000) begin
              d_sel = SEL_SUB; d_illegal = 1'b0;
            end
          end
          3'b111: begin d_sel = SEL_AND; d_illegal = !f7_zero; end
          3'b110: begin d_sel = SEL_OR;  d_illegal = !f7_zero; end
          3'b100: begin d_sel = SEL_XOR; d_illegal = !f7_zero; end
          3'b010: begin d_sel = SEL_SLT; d_illegal = !f7_zero; end
          3'b001: begin d_sel = SEL_SLL; d_illegal = !f7_zero; end
          3'b101: begin d_sel = SEL_SRL; d_illegal = !f7_zero; end
          default: d_illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        d_a = in_rs1;
        d_b = in_imm;
        case (in_funct3)
          3'b000: begin d_sel = SEL_ADD; d_illegal = 1'b0; end
          3'b111: begin d_sel = SEL_AND; d_illegal = 1'b0; end
          3'b110: begin d_sel = SEL_OR;  d_illegal = 1'b0; end
          3'b100: begin d_sel = SEL_XOR; d_illegal = 1'b0; end
          3'b010: begin d_sel = SEL_SLT; d_illegal = 1'b0; end
          // imm[11:5] nonzero on a right shift is SRAI, which the ALU cannot do
          3'b001: begin d_sel = SEL_SLL; d_illegal = !shamt_ok; end
          3'b101: begin d_sel = SEL_SRL; d_illegal = !shamt_ok; end
          default: d_illegal = 1'b1;
        endcase
      end
      7'b1100011: begin
        d_a   = in_rs1;
        d_b   = in_rs2;
        d_sel = SEL_SUB;
        if (in_funct3 == 3'b000) begin
          d_kind = K_BEQ; d_illegal = 1'b0;
        end else if (in_funct3 == 3'b001) begin
          d_kind = K_BNE; d_illegal = 1'b0;
        end
      end
      default: d_illegal = 1'b1;
    endcase
    // Illegal ops present a quiet all-zero ADD to the ALU
    if (d_illegal) begin
      d_a    = '0;
      d_b    = '0;
      d_sel  = SEL_ADD;
      d_kind = K_ALU;
    end
  end

  logic            s1_valid;
  logic [XLEN-1:0] s1_a, s1_b;
  logic [2:0]      s1_sel;
  logic [RD_W-1:0] s1_rd;
  kind_t           s1_kind;
  logic            s1_illegal;
  logic            advance, accept;

  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;
  assign accept   = in_valid && in_ready;

  assign alu_a   = s1_a;
  assign alu_b   = s1_b;
  assign alu_sel = s1_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_sel     <= '0;
      s1_rd      <= '0;
      s1_kind    <= K_ALU;
      s1_illegal <= 1'b0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_a       <= d_a;
      s1_b       <= d_b;
      s1_sel     <= d_sel;
      s1_rd      <= in_rd;
      s1_kind    <= d_kind;
      s1_illegal <= d_illegal;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_wb_en   <= 1'b0;
      out_branch  <= 1'b0;
      out_taken   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result  <= (s1_illegal || s1_kind != K_ALU) ? '0 : alu_result;
        out_rd      <= s1_rd;
        out_wb_en   <= !s1_illegal && (s1_kind == K_ALU);
        out_branch  <= !s1_illegal && (s1_kind != K_ALU);
        out_taken   <= (s1_kind == K_BEQ) ? alu_zero :
                       (s1_kind == K_BNE) ? !alu_zero : 1'b0;
        out_illegal <= s1_illegal;
      end
    end
  end

endmodule
